// File: rtl/xm23_pipe_pkg.sv
// Shared constants and helpers for the post-decode pipeline register chain.
// The slot record is a macro so its widths can follow each instance's parameters.
`define XM23_PIPE_SLOT_T(DW, IW) struct packed { logic valid; logic wr_en; logic [(IW)-1:0] dst; logic [(DW)-1:0] data; }

package xm23_pipe_pkg;

    localparam int STG_EXEC   = 0;
    localparam int STG_MEM    = 1;
    localparam int STG_WB     = 2;
    localparam int MAX_STAGES = 8;

    function automatic logic [3:0] popcount8(input logic [MAX_STAGES-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage register: selects flush, hold, bubble or capture of the
// upstream entry; also exposes its next-state valid for the occupancy count.
module pipe_stage_slot #(
    parameter int DATA_W    = 64,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 hold,
    input  logic                 bubble,
    input  logic                 prev_valid,
    input  logic                 prev_wr_en,
    input  logic [REG_IDX_W-1:0] prev_dst,
    input  logic [DATA_W-1:0]    prev_data,
    output logic                 valid,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] dst,
    output logic [DATA_W-1:0]    data,
    output logic                 valid_nxt
);

    typedef `XM23_PIPE_SLOT_T(DATA_W, REG_IDX_W) pipe_slot_t;

    pipe_slot_t cur;
    pipe_slot_t nxt;

    // Flush outranks hold so a killed entry cannot linger in a stalled stage.
    always_comb begin
        nxt = cur;
        if (flush) begin
            nxt = '0;
        end else if (hold) begin
            nxt = cur;
        end else if (bubble) begin
            nxt = '0;
        end else begin
            nxt.valid = prev_valid;
            nxt.wr_en = prev_wr_en;
            nxt.dst   = prev_dst;
            nxt.data  = prev_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign valid     = cur.valid;
    assign wr_en     = cur.wr_en;
    assign dst       = cur.dst;
    assign data      = cur.data;
    assign valid_nxt = nxt.valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// Execute..writeback register chain with stall/bubble, flush, operand
// forwarding lookup and occupancy / stall performance counters.
module pipe_stage_chain
    import xm23_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = 64,
    parameter int REG_IDX_W  = 3,
    parameter int NUM_SRC    = 2,
    parameter int RES_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic [REG_IDX_W-1:0]                   in_dst,
    input  logic                                   in_wr_en,
    output logic                                   in_ready,
    input  logic [NUM_STAGES-1:0]                  stall_in,
    input  logic [NUM_STAGES-1:0]                  flush_in,
    input  logic [NUM_STAGES-1:0][RES_W-1:0]       stage_res,
    output logic [NUM_STAGES-1:0]                  stage_valid,
    output logic [NUM_STAGES-1:0][DATA_W-1:0]      stage_data,
    output logic [NUM_STAGES-1:0][REG_IDX_W-1:0]   stage_dst,
    input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]      src_idx,
    output logic [NUM_SRC-1:0]                     fwd_hit,
    output logic [NUM_SRC-1:0][NUM_STAGES-1:0]     fwd_stage,
    output logic [NUM_SRC-1:0][RES_W-1:0]          fwd_data,
    output logic                                   ret_valid,
    output logic [DATA_W-1:0]                      ret_data,
    output logic [$clog2(NUM_STAGES+1)-1:0]        occupancy,
    output logic [CNT_W-1:0]                       stall_cycles
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] stage_wr_en;
    logic [NUM_STAGES-1:0] valid_nxt;

    // A stall propagates toward stage 0: older stages stalling freeze younger ones.
    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = stall_in[NUM_STAGES-1];
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            hold[k] = stall_in[k] | hold[k+1];
        end
    end

    assign in_ready = ~hold[0];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                 prev_valid;
        logic                 prev_wr_en;
        logic [REG_IDX_W-1:0] prev_dst;
        logic [DATA_W-1:0]    prev_data;
        logic                 bubble;

        if (k == STG_EXEC) begin : g_head
            assign prev_valid = in_valid;
            assign prev_wr_en = in_wr_en;
            assign prev_dst   = in_dst;
            assign prev_data  = in_data;
            assign bubble     = 1'b0;
        end else begin : g_body
            assign prev_valid = stage_valid[k-1];
            assign prev_wr_en = stage_wr_en[k-1];
            assign prev_dst   = stage_dst[k-1];
            assign prev_data  = stage_data[k-1];
            assign bubble     = hold[k-1] & ~hold[k];
        end

        pipe_stage_slot #(
            .DATA_W    (DATA_W),
            .REG_IDX_W (REG_IDX_W)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (flush_in[k]),
            .hold       (hold[k]),
            .bubble     (bubble),
            .prev_valid (prev_valid),
            .prev_wr_en (prev_wr_en),
            .prev_dst   (prev_dst),
            .prev_data  (prev_data),
            .valid      (stage_valid[k]),
            .wr_en      (stage_wr_en[k]),
            .dst        (stage_dst[k]),
            .data       (stage_data[k]),
            .valid_nxt  (valid_nxt[k])
        );
    end

    assign ret_valid = stage_valid[NUM_STAGES-1] & ~stall_in[NUM_STAGES-1]
                     & ~flush_in[NUM_STAGES-1];
    assign ret_data  = stage_data[NUM_STAGES-1];

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        fwd_hit   = '0;
        fwd_stage = '0;
        fwd_data  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (stage_valid[k] && stage_wr_en[k] && (stage_dst[k] == src_idx[s])) begin
                    fwd_hit[s]      = 1'b1;
                    fwd_stage[s]    = '0;
                    fwd_stage[s][k] = 1'b1;
                    fwd_data[s]     = stage_res[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy    <= '0;
            stall_cycles <= '0;
        end else begin
            occupancy <= OCC_W'(popcount8(MAX_STAGES'(valid_nxt)));
            if (hold[0] && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the fixed three-deep decode/execute/memory/writeback shift register.
- Carries an opaque payload per stage, plus a valid bit, destination register index and write-enable.
- Adds per-stage stall (hold plus bubble insertion), per-stage flush, forwarding lookup for N source operands, and occupancy/stall performance counters.
- Sits between decode and the execute, memory and writeback datapaths; stage 0 is execute and stage NUM_STAGES-1 is writeback.

Parameters:
- NUM_STAGES, 3: pipeline depth after decode; legal range 2..8.
- DATA_W, 64: payload width per stage (decode fields plus enables).
- REG_IDX_W, 3: destination/source register index width.
- NUM_SRC, 2: number of forwarding lookup ports.
- RES_W, 16: result width used for forwarding.
- CNT_W, 16: width of the performance counters.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: decode presents an instruction.
- in_data, in, DATA_W: decoded payload.
- in_dst, in, REG_IDX_W: destination register.
- in_wr_en, in, 1: instruction writes in_dst.
- in_ready, out, 1: stage 0 accepts this cycle.
- stall_in, in, NUM_STAGES: bit k requests stage k to hold.
- flush_in, in, NUM_STAGES: bit k kills the entry entering/held in stage k.
- stage_res, in, NUM_STAGES x RES_W: current result computed in each stage.
- stage_valid, out, NUM_STAGES: valid per stage.
- stage_data, out, NUM_STAGES x DATA_W: payload per stage.
- stage_dst, out, NUM_STAGES x REG_IDX_W: destination per stage.
- src_idx, in, NUM_SRC x REG_IDX_W: operand indices for lookup.
- fwd_hit, out, NUM_SRC: a match exists in some stage.
- fwd_stage, out, NUM_SRC x NUM_STAGES: one-hot of the matching stage.
- fwd_data, out, NUM_SRC x RES_W: forwarded value.
- ret_valid, out, 1: last stage retires this cycle.
- ret_data, out, DATA_W: retiring payload.
- occupancy, out, $clog2(NUM_STAGES+1): count of valid stages.
- stall_cycles, out, CNT_W: saturating count of cycles with in_ready=0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All valid, data, dst and wr_en registers go to 0.
  - Both counters go to 0.
  - Outputs follow: in_ready=1, ret_valid=0, fwd_hit=0, occupancy=0.
- Hold chain (combinational): hold[N-1]=stall_in[N-1]; hold[k]=stall_in[k] | hold[k+1].
  - A stall at any stage freezes every younger stage.
- in_ready = ~hold[0].
- Per-stage update on the rising clock edge, first matching rule wins:
  - flush_in[k]: valid[k] <= 0. Data is don't-care; data <= 0 is preferred. Flush beats hold.
  - hold[k]: stage k keeps its contents.
  - k>0 and hold[k-1] & ~hold[k]: bubble inserted, valid[k] <= 0.
  - k>0 otherwise: stage k <= stage k-1 (valid, data, dst, wr_en).
  - k=0 otherwise: stage 0 <= {in_valid, in_data, in_dst, in_wr_en}.
- Latency: an accepted instruction reaches stage k after k+1 cycles when there are no stalls.
- Retire (combinational): ret_valid = valid[N-1] & ~stall_in[N-1] & ~flush_in[N-1]; ret_data = data[N-1].
- Forwarding (combinational), per source port s:
  - Candidates: stages with valid & wr_en & dst == src_idx[s].
  - The lowest stage index among candidates (youngest) wins.
  - Outputs: fwd_stage one-hot of the winner; fwd_hit = any candidate; fwd_data = stage_res of the winner, else 0.
  - Flushed or bubble stages never match.
- occupancy: registered popcount of the next-state valid bits, updated every clock.
- stall_cycles: increments when hold[0]=1; saturates at all-ones and does not wrap.
- Boundary conditions:
  - All stall bits set: chain frozen and ret_valid=0.
  - stall_in[k] and flush_in[k] together: stage empties and stages < k hold.
  - flush_in all ones: every stage empties next cycle regardless of stalls; in_valid that cycle is dropped.
  - in_valid while hold[0]: not captured. Decode must re-present it; in_ready=0 signals this.
  - Reset asserted mid-stall or mid-flush: all state clears immediately; the first cycle after release behaves as empty.

Decomposition:
- Package xm23_pipe_pkg holds:
  - Stage index constants: STG_EXEC=0, STG_MEM=1, STG_WB=2.
  - typedef pipe_slot_t {valid, wr_en, dst, data} as a parametrised struct or macro.
  - The popcount function.
- Sub-module pipe_stage_slot: one stage register with capture/hold/bubble/flush select. It is instantiated NUM_STAGES times by a generate loop.
- The hold chain, forwarding priority and counters stay in the top level.

Test Plan:
- Flow: NUM_STAGES=3, no stalls, inject payloads 0x11, 0x22, 0x33 on consecutive cycles.
  - ret_data 0x11 at cycle 3, 0x22 at cycle 4, 0x33 at cycle 5.
  - occupancy goes 1,2,3 then drains 2,1,0.
- Stall/bubble: stall_in=3'b010 for 2 cycles with the chain full.
  - Stages 0,1 hold; stage 2 gets valid=0 (bubble); ret_valid=0 the following cycle.
  - in_ready=0 and stall_cycles=2.
- Flush priority: stall_in=3'b001 and flush_in=3'b001 in the same cycle.
  - stage_valid[0]=0 next cycle; stages 1,2 advance.
  - A new in_valid is accepted the cycle after.
- Forwarding: dst=5 in stage 0 and stage 2, both wr_en, with src_idx[0]=5 and stage_res={0xAAAA,0xBBBB,0xCCCC}.
  - fwd_stage=3'b001, fwd_data=0xAAAA.
  - With wr_en=0 in stage 0: fwd_data=0xCCCC.
- Counter saturation: CNT_W=4, hold stall_in[0] for 20 cycles → stall_cycles stops at 15.
- Async reset: assert reset_n low between clock edges with the chain full.
  - All stage_valid=0 and counters=0 immediately, with no clock edge required.
